rm1_fht_decoder: RTL and testbench
==================================

RM1_FHT_DECODER -- requirements
Module: rm1_fht_decoder

Interface
REQ-001 SHALL have parameter M, default 4, meaning code order m of RM(1,m), legal range 3..6.
REQ-002 SHALL derive N = 2^M (codeword length), K = M+1 (message length) and W = M+2 (signed coefficient width); none of these is user-overridable.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port rst  input  1  reset, synchronous to clk, active-high.
REQ-005 SHALL have port r  input  N  received hard-decision word; bit j is codeword position j.
REQ-006 SHALL have port in_valid  input  1  r is valid this cycle.
REQ-007 SHALL have port in_ready  output  1  block can accept r.
REQ-008 SHALL have port message  output  K  decoded message: bit 0 is the complement bit, bits M:1 are the linear index.
REQ-009 SHALL have port err_count  output  M+1  number of bit positions corrected.
REQ-010 SHALL have port ambiguous  output  1  a maximum-|F| tie existed.
REQ-011 SHALL have port out_valid  output  1  message, err_count and ambiguous are valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the result.

Function
REQ-013 SHALL use this code definition: codeword bit j = message[0] XOR parity(j AND message[M:1]).
REQ-014 SHALL run the FSM states IDLE -> FHT -> SEARCH -> DONE -> IDLE.
REQ-015 SHALL drive in_ready = 1 only in IDLE; it SHALL accept r on a cycle with in_valid & in_ready.
REQ-016 SHALL, on accept, load coefficient register F[j] = +1 if r[j] = 0 and -1 if r[j] = 1, then enter FHT with stage counter 0.
REQ-017 SHALL, in FHT, perform one full Hadamard butterfly stage per cycle: stage s pairs j with j+2^s (bit s of j = 0) as (a+b, a-b). After stage M-1 it SHALL enter SEARCH with index 0.
REQ-018 SHALL compute all arithmetic in W-bit two's complement, with no saturation; |F| never exceeds N.
REQ-019 SHALL, in SEARCH, examine one index per cycle for N cycles and keep best_idx, best_mag and best_neg.
REQ-020 SHALL replace the held best only when |F[i]| > best_mag (strict), so the lowest index wins ties.
REQ-021 SHALL set the tie flag when |F[i]| = best_mag and i > 0, and clear it whenever the best is replaced.
REQ-022 SHALL, in DONE, hold message = {best_idx, best_neg}, err_count = (N - best_mag)/2, ambiguous = tie flag, and out_valid = 1.
REQ-023 SHALL hold all outputs stable while out_valid & !out_ready.
REQ-024 SHALL return to IDLE on out_valid & out_ready; in_ready SHALL rise on the following cycle.
REQ-025 SHALL give fixed latency: out_valid asserts exactly M+N+1 cycles after the accept edge.
REQ-026 SHALL ignore in_valid outside IDLE; r need not be held after accept.
REQ-027 SHALL keep message, err_count and ambiguous at their last values when out_valid = 0; they are don't-care to consumers.

Reset
REQ-028 SHALL, on rst = 1 at a clk edge, enter IDLE, drive out_valid = 0 and in_ready = 1 from the next cycle, and clear message, err_count, ambiguous, the counters and the best registers to 0.
REQ-029 SHALL abort any in-flight decode on reset mid-FHT, mid-SEARCH or in DONE; no result from an aborted decode SHALL ever appear.
REQ-030 SHALL give rst priority over a simultaneous in_valid or out_ready.

Structure
REQ-031 SHALL place M limits, the state enumeration and the err_count formula helper in shared package rm_pkg.
REQ-032 SHALL implement one combinational sub-module, rm_fht_stage (parameters M; inputs F vector and stage index; output next F vector), instantiated once and reused every FHT cycle.
REQ-033 SHALL use no memories; F is N x W flip-flops.

Verification (M=4, N=16, latency 21)
REQ-034 SHALL cover: r=16'h0000 -> message 5'b00000, err_count 0, ambiguous 0; r=16'hFFFF -> message 5'b00001, err_count 0.
REQ-035 SHALL cover: r=16'hAAAA -> message 5'b00010; r=16'hAAAB -> message 5'b00010, err_count 1, ambiguous 0.
REQ-036 SHALL cover: r=16'h000F -> message 5'b00000, err_count 4, ambiguous 1, because the index 4 tie is resolved to the lowest index.
REQ-037 SHALL cover: out_ready held 0 for 10 cycles after out_valid -> outputs stable, in_ready 0; then one out_ready pulse -> in_ready 1 on the next cycle.
REQ-038 SHALL cover: rst pulsed during SEARCH of r=16'hAAAA, then r=16'h0000 sent -> only the result 5'b00000 is observed, 21 cycles after its accept.
REQ-039 SHALL cover: exhaustive sweep of all 32 codewords, each with every single-bit error -> correct message and err_count 1, back-to-back with out_ready tied to 1.

Source files
------------

// File: rtl/rm_pkg.sv
// Shared definitions for the first-order Reed-Muller FHT decoder:
// legal code-order range, controller state encoding and the error-count rule.
package rm_pkg;

    localparam int M_MIN = 3;
    localparam int M_MAX = 6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FHT,
        S_SEARCH,
        S_DONE
    } state_t;

    // A correlation magnitude of n - 2e corresponds to e disagreeing positions.
    function automatic int err_count_f(input int n, input int best_mag);
        return (n - best_mag) / 2;
    endfunction

endpackage

// File: rtl/rm_fht_stage.sv
// One full radix-2 Hadamard butterfly stage across all 2^M coefficients.
// Purely combinational; the decoder applies it once per FHT cycle.
module rm_fht_stage #(
    parameter int M = 4
) (
    input  logic [(2**M)*(M+2)-1:0] f_i,
    input  logic [$clog2(M)-1:0]    stage_i,
    output logic [(2**M)*(M+2)-1:0] f_o
);

    localparam int N = 2**M;
    localparam int W = M + 2;

    logic signed [W-1:0] f_a  [N];
    logic signed [W-1:0] nf_a [N];
    logic        [M-1:0] span;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign f_a[g]           = f_i[g*W +: W];
        assign f_o[g*W +: W]    = nf_a[g];
    end

    // Lower member of each pair takes a+b, upper member takes a-b; sums wrap.
    // NOTE: every nf_a element and span is assigned on every pass, so no latch is inferred.
    always_comb begin
        span = M'(1) << stage_i;
        for (int j = 0; j < N; j++) begin
            if ((M'(j) & span) == '0) begin
                nf_a[j] = f_a[j] + f_a[M'(j) | span];
            end else begin
                nf_a[j] = f_a[M'(j) & ~span] - f_a[j];
            end
        end
    end

endmodule

// File: rtl/rm1_fht_decoder.sv
// RM(1,M) maximum-likelihood hard-decision decoder: fast Hadamard transform of
// the +/-1 mapped word, then a serial search for the largest |coefficient|.
module rm1_fht_decoder
    import rm_pkg::*;
#(
    parameter int M = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2**M-1:0] r,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [M:0]      message,
    output logic [M:0]      err_count,
    output logic            ambiguous,
    output logic            out_valid,
    input  logic            out_ready
);

    localparam int N  = 2**M;
    localparam int K  = M + 1;
    localparam int W  = M + 2;
    localparam int SW = $clog2(M);

    if (M < M_MIN || M > M_MAX) begin : g_bad_m
        $error("rm1_fht_decoder: parameter M outside supported range");
    end

    state_t              state_q;
    logic [SW-1:0]       stage_q;
    logic [M-1:0]        idx_q;
    logic [M-1:0]        best_idx_q;
    logic [K-1:0]        best_mag_q;
    logic                best_neg_q;
    logic                tie_q;
    logic signed [W-1:0] f_q [N];

    logic [K-1:0]        message_q;
    logic [K-1:0]        err_count_q;
    logic                ambiguous_q;
    logic                out_valid_q;
    logic                in_ready_q;

    logic [N*W-1:0]      f_flat;
    logic [N*W-1:0]      f_d;
    logic signed [W-1:0] cur_f;
    logic [K-1:0]        cur_mag;

    for (genvar g = 0; g < N; g++) begin : g_flat
        assign f_flat[g*W +: W] = f_q[g];
    end

    rm_fht_stage #(
        .M (M)
    ) u_stage (
        .f_i     (f_flat),
        .stage_i (stage_q),
        .f_o     (f_d)
    );

    // |F| never exceeds N, so K bits hold the magnitude exactly.
    assign cur_f   = f_q[idx_q];
    assign cur_mag = cur_f[W-1] ? K'(-cur_f) : K'(cur_f);

    // NOTE: the coefficient array is pure datapath, fully loaded on every accept, so it carries no reset.
    always_ff @(posedge clk) begin
        for (int j = 0; j < N; j++) begin
            if (!rst && state_q == S_IDLE && in_valid && in_ready_q) begin
                f_q[j] <= r[j] ? W'(-1) : W'(1);
            end else if (!rst && state_q == S_FHT) begin
                f_q[j] <= f_d[j*W +: W];
            end
        end
    end

    // NOTE: all state below is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            stage_q     <= '0;
            idx_q       <= '0;
            best_idx_q  <= '0;
            best_mag_q  <= '0;
            best_neg_q  <= 1'b0;
            tie_q       <= 1'b0;
            message_q   <= '0;
            err_count_q <= '0;
            ambiguous_q <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        stage_q    <= '0;
                        idx_q      <= '0;
                        best_idx_q <= '0;
                        best_mag_q <= '0;
                        best_neg_q <= 1'b0;
                        tie_q      <= 1'b0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_FHT;
                    end
                end

                S_FHT: begin
                    stage_q <= stage_q + SW'(1);
                    if (stage_q == SW'(M - 1)) begin
                        idx_q   <= '0;
                        state_q <= S_SEARCH;
                    end
                end

                // Strict compare keeps the lowest index on ties.
                S_SEARCH: begin
                    if (cur_mag > best_mag_q) begin
                        best_idx_q <= idx_q;
                        best_mag_q <= cur_mag;
                        best_neg_q <= cur_f[W-1];
                        tie_q      <= 1'b0;
                    end else if (cur_mag == best_mag_q && idx_q != '0) begin
                        tie_q <= 1'b1;
                    end
                    idx_q <= idx_q + M'(1);
                    if (idx_q == M'(N - 1)) begin
                        state_q <= S_DONE;
                    end
                end

                S_DONE: begin
                    if (!out_valid_q) begin
                        message_q   <= {best_idx_q, best_neg_q};
                        err_count_q <= K'(err_count_f(N, int'(best_mag_q)));
                        ambiguous_q <= tie_q;
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign message   = message_q;
    assign err_count = err_count_q;
    assign ambiguous = ambiguous_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rm1_fht_decoder.sv
// Self-checking bench for rm1_fht_decoder (M=4): a direct-correlation reference
// model, directed corner cases, randomized traffic and an exhaustive 1-error sweep.
module tb_rm1_fht_decoder;

    localparam int M   = 4;
    localparam int N   = 16;
    localparam int K   = 5;
    localparam int LAT = M + N + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] r = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [K-1:0] message;
    logic [M:0]   err_count;
    logic         ambiguous;
    logic         out_valid;
    logic         out_ready = 1'b1;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    rm1_fht_decoder #(
        .M (M)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .r         (r),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .message   (message),
        .err_count (err_count),
        .ambiguous (ambiguous),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    typedef struct {
        logic [N-1:0] rv;
        int           acc;
        bit           has_lit;
        logic [K-1:0] lit_msg;
        int           lit_err;
        bit           chk_amb;
        bit           lit_amb;
    } txn_t;

    txn_t         q[$];
    bit           nx_has_lit, nx_chk_amb, nx_lit_amb;
    logic [K-1:0] nx_msg;
    int           nx_err;
    int           n_checks = 0;
    int           n_pass = 0;
    bit           rand_ready = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    endtask

    function automatic bit par(input int v);
        return bit'($countones(v) & 1);
    endfunction

    function automatic logic [N-1:0] encode(input int msg);
        logic [N-1:0] cw;
        for (int j = 0; j < N; j++) cw[j] = bit'(msg & 1) ^ par(j & (msg >> 1));
        return cw;
    endfunction

    // Correlate the received word against every linear codeword directly.
    function automatic void model(input logic [N-1:0] rv, output logic [K-1:0] msg,
                                  output int err, output bit amb);
        int best_mag, best_idx, f, mag;
        bit best_neg;
        best_mag = 0; best_idx = 0; best_neg = 0; amb = 0;
        for (int k = 0; k < N; k++) begin
            f = 0;
            for (int j = 0; j < N; j++) f += (rv[j] ^ par(j & k)) ? -1 : 1;
            mag = (f < 0) ? -f : f;
            if (mag > best_mag) begin
                best_mag = mag; best_idx = k; best_neg = (f < 0); amb = 0;
            end else if (mag == best_mag && k > 0) begin
                amb = 1;
            end
        end
        msg = K'((best_idx << 1) | int'(best_neg));
        err = (N - best_mag) / 2;
    endfunction

    bit prev_ov = 0;
    bit hs_prev = 0;

    always @(negedge clk) begin : mon
        txn_t         t;
        logic [K-1:0] em;
        int           ee;
        bit           ea;
        if (rst) begin
            q.delete();
            prev_ov = 0;
            hs_prev = 0;
        end else begin
            if (hs_prev) begin
                check("in_ready_after_ack", in_ready, 1);
                check("out_valid_after_ack", out_valid, 0);
            end
            hs_prev = 0;
            if (in_valid && in_ready) begin
                t.rv = r; t.acc = cyc + 1; t.has_lit = nx_has_lit; t.lit_msg = nx_msg;
                t.lit_err = nx_err; t.chk_amb = nx_chk_amb; t.lit_amb = nx_lit_amb;
                q.push_back(t);
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_out_valid", 1, 0);
                end else begin
                    t = q[0];
                    model(t.rv, em, ee, ea);
                    check("message", message, em);
                    check("err_count", err_count, ee);
                    check("ambiguous", ambiguous, ea);
                    check("in_ready_while_valid", in_ready, 0);
                    if (!prev_ov) check("latency", cyc - t.acc, LAT);
                    if (out_ready) begin
                        if (t.has_lit) begin
                            check("lit_message", message, t.lit_msg);
                            check("lit_err_count", err_count, t.lit_err);
                            if (t.chk_amb) check("lit_ambiguous", ambiguous, t.lit_amb);
                        end
                        void'(q.pop_front());
                        hs_prev = 1;
                    end
                end
            end
            prev_ov = out_valid;
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [N-1:0] v, input bit hl, input logic [K-1:0] lm,
                        input int le, input bit ca, input bit la);
        int n;
        n = 0;
        nx_has_lit = hl; nx_msg = lm; nx_err = le; nx_chk_amb = ca; nx_lit_amb = la;
        r = v;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("send_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        r = N'($urandom);
    endtask

    task automatic wait_result();
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) check("result_timeout", 0, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 500) begin
            sync();
            n++;
        end
        if (q.size() != 0) check("drain_timeout", 0, 1);
    endtask

    initial begin : stim
        logic [K-1:0] em;
        int           ee;
        bit           ea;
        logic [N-1:0] v;

        // Pin the reference model to hand-derived results.
        model(16'h000F, em, ee, ea);
        check("model_000F_msg", em, 0);
        check("model_000F_err", ee, 4);
        check("model_000F_amb", ea, 1);
        model(16'hAAAB, em, ee, ea);
        check("model_AAAB_msg", em, 5'b00010);
        check("model_AAAB_err", ee, 1);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_message", message, 0);
        check("rst_err_count", err_count, 0);
        check("rst_ambiguous", ambiguous, 0);
        sync();

        send(16'h0000, 1, 5'b00000, 0, 1, 0);
        send(16'hFFFF, 1, 5'b00001, 0, 0, 0);
        send(16'hAAAA, 1, 5'b00010, 0, 0, 0);
        send(16'hAAAB, 1, 5'b00010, 1, 1, 0);
        send(16'h000F, 1, 5'b00000, 4, 1, 1);
        drain();

        // Back-pressure: result must hold for 10 cycles, then one ready pulse.
        out_ready = 1'b0;
        send(16'hAAAB, 1, 5'b00010, 1, 1, 0);
        wait_result();
        repeat (10) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_message", message, 5'b00010);
            check("hold_err_count", err_count, 1);
            check("hold_in_ready", in_ready, 0);
        end
        sync();
        out_ready = 1'b1;
        sync();
        out_ready = 1'b0;
        @(negedge clk);
        check("pulse_in_ready", in_ready, 1);
        check("pulse_out_valid", out_valid, 0);
        sync();
        out_ready = 1'b1;

        // Reset in the middle of SEARCH must discard that decode.
        send(16'hAAAA, 0, '0, 0, 0, 0);
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        sync();
        rst = 1'b0;
        send(16'h0000, 1, 5'b00000, 0, 1, 0);
        drain();

        // Reset while a result is held in DONE.
        out_ready = 1'b0;
        send(16'h00FF, 0, '0, 0, 0, 0);
        wait_result();
        sync();
        rst = 1'b1;
        sync();
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("done_rst_out_valid", out_valid, 0);
        check("done_rst_in_ready", in_ready, 1);
        check("done_rst_message", message, 0);
        check("done_rst_err_count", err_count, 0);
        sync();

        // Randomized traffic with random back-pressure.
        rand_ready = 1;
        for (int i = 0; i < 120; i++) begin
            if (i % 2 == 0) begin
                v = encode(int'($urandom_range(0, 31)));
                for (int e = int'($urandom_range(0, 3)); e > 0; e--)
                    v ^= N'(1) << $urandom_range(0, N - 1);
            end else begin
                v = N'($urandom);
            end
            send(v, 0, '0, 0, 0, 0);
        end
        rand_ready = 0;
        sync();
        out_ready = 1'b1;
        drain();

        // Every codeword with every single-bit error, back to back.
        for (int m = 0; m < 32; m++) begin
            for (int b = 0; b < N; b++) begin
                send(encode(m) ^ (N'(1) << b), 1, K'(m), 1, 1, 0);
            end
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
